// File: rtl/npg_pkg.sv
// Shared definitions for the neurostimulator channel scheduler.
// Holds the scheduler state encoding, the per-channel configuration field
// widths and the counter widths used by npg_channel_scheduler and
// npg_rr_arbiter. No ports.
package npg_pkg;

    localparam int unsigned ELEC_W = 4;   // electrode switch mask
    localparam int unsigned AMP_W  = 6;   // amplitude code
    localparam int unsigned PH_W   = 3;   // phase duration code
    localparam int unsigned CH_W   = 3;   // channel index (up to 8 channels)
    localparam int unsigned WDOG_W = 10;  // completion watchdog
    localparam int unsigned GAP_W  = 4;   // inter-pulse gap counter

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StGap
    } state_t;

endpackage

// File: rtl/npg_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   pending     in  N_CH  channels requesting service
//   rr_ptr      in  CH_W  index of the most recently granted channel
//   grant_valid out 1     at least one channel pending
//   grant_idx   out CH_W  winner: first pending index after rr_ptr, wrapping
module npg_rr_arbiter
    import npg_pkg::*;
#(
    parameter int unsigned N_CH = 4
) (
    input  logic [N_CH-1:0] pending,
    input  logic [CH_W-1:0] rr_ptr,
    output logic            grant_valid,
    output logic [CH_W-1:0] grant_idx
);

    logic [N_CH-1:0] mask;
    logic [N_CH-1:0] masked;

    // Channels above rr_ptr get first pick; if none of them are pending the
    // search wraps to the lowest pending index overall.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N_CH; i++) begin
            mask[i] = (CH_W'(i) > rr_ptr);
        end
        masked    = pending & mask;
        grant_idx = '0;
        if (masked != '0) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (masked[i]) grant_idx = CH_W'(i);
            end
        end else begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (pending[i]) grant_idx = CH_W'(i);
            end
        end
    end

    assign grant_valid = |pending;

endmodule

// File: rtl/npg_channel_scheduler.sv
// Shares one biphasic pulse engine among N_CH stimulation channels.
// Per-channel one-cycle requests are queued (one per channel), granted
// round-robin, and the winner's configuration is snapshotted onto out_*
// before the engine is started. A watchdog aborts a pulse whose done strobe
// never arrives, and a fixed idle gap separates consecutive pulses.
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   enable, ch_enable            global / per-channel enables
//   pulse_req                    one-cycle request per channel
//   cfg_electrode1/2, cfg_amplitude, cfg_phase   packed per-channel config
//   pulse_done                   engine completion strobe
//   clear_flags                  clears overrun and timeout_err
//   pulse_start                  one-cycle engine start strobe
//   out_electrode1/2, out_amplitude, out_phase   latched granted config
//   active_ch                    granted channel index
//   busy                         high outside IDLE
//   overrun, timeout_err         sticky error flags
module npg_channel_scheduler
    import npg_pkg::*;
#(
    parameter int unsigned N_CH           = 4,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic [N_CH-1:0]          ch_enable,
    input  logic [N_CH-1:0]          pulse_req,
    input  logic [ELEC_W*N_CH-1:0]   cfg_electrode1,
    input  logic [ELEC_W*N_CH-1:0]   cfg_electrode2,
    input  logic [AMP_W*N_CH-1:0]    cfg_amplitude,
    input  logic [PH_W*N_CH-1:0]     cfg_phase,
    input  logic                     pulse_done,
    input  logic                     clear_flags,
    output logic                     pulse_start,
    output logic [ELEC_W-1:0]        out_electrode1,
    output logic [ELEC_W-1:0]        out_electrode2,
    output logic [AMP_W-1:0]         out_amplitude,
    output logic [PH_W-1:0]          out_phase,
    output logic [CH_W-1:0]          active_ch,
    output logic                     busy,
    output logic [N_CH-1:0]          overrun,
    output logic                     timeout_err
);

    state_t              state_q;
    logic [N_CH-1:0]     pending_q, pending_d;
    logic [N_CH-1:0]     overrun_q;
    logic [CH_W-1:0]     rr_ptr_q;
    logic [WDOG_W-1:0]   wdog_q;
    logic [GAP_W-1:0]    gap_q;
    logic                timeout_q;
    logic                pulse_start_q;
    logic                busy_q;
    logic [ELEC_W-1:0]   e1_q, e2_q;
    logic [AMP_W-1:0]    amp_q;
    logic [PH_W-1:0]     ph_q;
    logic [CH_W-1:0]     active_q;

    logic                grant_valid;
    logic [CH_W-1:0]     grant_idx;
    logic                take;
    logic [N_CH-1:0]     grant_oh;
    logic [N_CH-1:0]     req_ok;
    logic [N_CH-1:0]     overrun_set;
    logic [ELEC_W-1:0]   sel_e1, sel_e2;
    logic [AMP_W-1:0]    sel_amp;
    logic [PH_W-1:0]     sel_ph;

    npg_rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .pending     (pending_q),
        .rr_ptr      (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign take   = enable && (state_q == StIdle) && grant_valid;
    assign req_ok = pulse_req & ch_enable & {N_CH{enable}};

    always_comb begin
        grant_oh = '0;
        sel_e1   = '0;
        sel_e2   = '0;
        sel_amp  = '0;
        sel_ph   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_idx == CH_W'(i)) begin
                grant_oh[i] = take;
                sel_e1      = cfg_electrode1[i*ELEC_W +: ELEC_W];
                sel_e2      = cfg_electrode2[i*ELEC_W +: ELEC_W];
                sel_amp     = cfg_amplitude[i*AMP_W +: AMP_W];
                sel_ph      = cfg_phase[i*PH_W +: PH_W];
            end
        end
    end

    // A new request re-arms the bit even if it is being granted this cycle;
    // a disabled channel (or global disable) drops whatever it had queued.
    assign pending_d   = req_ok | (pending_q & ~grant_oh & ch_enable & {N_CH{enable}});
    assign overrun_set = req_ok & pending_q & ~grant_oh;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            pending_q     <= '0;
            overrun_q     <= '0;
            rr_ptr_q      <= CH_W'(N_CH - 1);
            wdog_q        <= '0;
            gap_q         <= '0;
            timeout_q     <= 1'b0;
            pulse_start_q <= 1'b0;
            busy_q        <= 1'b0;
            e1_q          <= '0;
            e2_q          <= '0;
            amp_q         <= '0;
            ph_q          <= '0;
            active_q      <= '0;
        end else begin
            pending_q     <= pending_d;
            overrun_q     <= (overrun_q & ~{N_CH{clear_flags}}) | overrun_set;
            pulse_start_q <= 1'b0;
            if (clear_flags) timeout_q <= 1'b0;

            if (!enable) begin
                state_q  <= StIdle;
                busy_q   <= 1'b0;
                e1_q     <= '0;
                e2_q     <= '0;
                amp_q    <= '0;
                ph_q     <= '0;
                active_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (grant_valid) begin
                            e1_q          <= sel_e1;
                            e2_q          <= sel_e2;
                            amp_q         <= sel_amp;
                            ph_q          <= sel_ph;
                            active_q      <= grant_idx;
                            rr_ptr_q      <= grant_idx;
                            pulse_start_q <= 1'b1;
                            busy_q        <= 1'b1;
                            state_q       <= StStart;
                        end
                    end
                    StStart: begin
                        wdog_q  <= WDOG_W'(TIMEOUT_CYCLES);
                        state_q <= StWait;
                    end
                    StWait: begin
                        if (pulse_done) begin
                            gap_q   <= GAP_W'(GAP_CYCLES);
                            state_q <= StGap;
                        end else if (wdog_q == WDOG_W'(1)) begin
                            // Counter would reach zero this edge: abort.
                            timeout_q <= 1'b1;
                            gap_q     <= GAP_W'(GAP_CYCLES);
                            state_q   <= StGap;
                        end else begin
                            wdog_q <= wdog_q - WDOG_W'(1);
                        end
                    end
                    StGap: begin
                        if (gap_q == GAP_W'(1)) begin
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            gap_q <= gap_q - GAP_W'(1);
                        end
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign pulse_start    = pulse_start_q;
    assign busy           = busy_q;
    assign out_electrode1 = e1_q;
    assign out_electrode2 = e2_q;
    assign out_amplitude  = amp_q;
    assign out_phase      = ph_q;
    assign active_ch      = active_q;
    assign overrun        = overrun_q;
    assign timeout_err    = timeout_q;

endmodule

// File: tb/tb_npg_channel_scheduler.sv
// Directed self-checking bench for npg_channel_scheduler.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_npg_channel_scheduler;

    localparam int N_CH = 4;
    localparam int GAP  = 2;
    localparam int TO   = 64;

    logic            clk;
    logic            resetn;
    logic            enable;
    logic [3:0]      ch_enable;
    logic [3:0]      pulse_req;
    logic [15:0]     cfg_electrode1;
    logic [15:0]     cfg_electrode2;
    logic [23:0]     cfg_amplitude;
    logic [11:0]     cfg_phase;
    logic            pulse_done;
    logic            clear_flags;
    logic            pulse_start;
    logic [3:0]      out_electrode1;
    logic [3:0]      out_electrode2;
    logic [5:0]      out_amplitude;
    logic [2:0]      out_phase;
    logic [2:0]      active_ch;
    logic            busy;
    logic [3:0]      overrun;
    logic            timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int start_cyc = 0;
    int done_cyc  = 0;

    npg_channel_scheduler #(
        .N_CH           (N_CH),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .enable         (enable),
        .ch_enable      (ch_enable),
        .pulse_req      (pulse_req),
        .cfg_electrode1 (cfg_electrode1),
        .cfg_electrode2 (cfg_electrode2),
        .cfg_amplitude  (cfg_amplitude),
        .cfg_phase      (cfg_phase),
        .pulse_done     (pulse_done),
        .clear_flags    (clear_flags),
        .pulse_start    (pulse_start),
        .out_electrode1 (out_electrode1),
        .out_electrode2 (out_electrode2),
        .out_amplitude  (out_amplitude),
        .out_phase      (out_phase),
        .active_ch      (active_ch),
        .busy           (busy),
        .overrun        (overrun),
        .timeout_err    (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_cfg(input int ch, input logic [3:0] e1, input logic [3:0] e2,
                           input logic [5:0] amp, input logic [2:0] ph);
        cfg_electrode1[ch*4 +: 4] = e1;
        cfg_electrode2[ch*4 +: 4] = e2;
        cfg_amplitude[ch*6 +: 6]  = amp;
        cfg_phase[ch*3 +: 3]      = ph;
    endtask

    task automatic request(input logic [3:0] mask);
        pulse_req = mask;
        tick();
        pulse_req = '0;
    endtask

    task automatic wait_start(input int limit, output bit found);
        int k;
        k = 0;
        while (!pulse_start && k < limit) begin
            tick();
            k++;
        end
        found = pulse_start;
    endtask

    task automatic take_start(input string tag, input int ch, input int amp, input bit chk_gap);
        bit f;
        wait_start(20, f);
        check_eq({tag, "_start"}, f, 1);
        check_eq({tag, "_ch"}, active_ch, ch);
        check_eq({tag, "_amp"}, out_amplitude, amp);
        if (chk_gap) check_eq({tag, "_gap"}, cyc - done_cyc, GAP + 2);
        start_cyc = cyc;
    endtask

    task automatic finish_pulse();
        pulse_done = 1'b1;
        done_cyc   = cyc;
        tick();
        pulse_done = 1'b0;
    endtask

    task automatic serve(input string tag, input int ch, input int amp, input bit chk_gap);
        take_start(tag, ch, amp, chk_gap);
        tick();
        tick();
        finish_pulse();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        bit f;
        int s;
        resetn = 1'b0;
        enable = 1'b1;
        ch_enable = 4'hf;
        pulse_req = '0;
        pulse_done = 1'b0;
        clear_flags = 1'b0;
        cfg_electrode1 = '0;
        cfg_electrode2 = '0;
        cfg_amplitude = '0;
        cfg_phase = '0;
        set_cfg(0, 4'b1000, 4'b0001, 6'd5,  3'd1);
        set_cfg(1, 4'b0010, 4'b1000, 6'd12, 3'd2);
        set_cfg(2, 4'b0001, 4'b0100, 6'd20, 3'd3);
        set_cfg(3, 4'b0100, 4'b0010, 6'd50, 3'd7);

        // Reset state
        tick();
        check_eq("rst_start", pulse_start, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_amp", out_amplitude, 0);
        check_eq("rst_ovr", overrun, 0);
        do_reset();
        check_eq("rst_active", active_ch, 0);
        check_eq("rst_tmo", timeout_err, 0);

        // Single request on ch2: start two cycles after the request
        request(4'b0100);
        check_eq("s1_idle_start", pulse_start, 0);
        check_eq("s1_idle_busy", busy, 0);
        tick();
        check_eq("s1_start", pulse_start, 1);
        check_eq("s1_ch", active_ch, 2);
        check_eq("s1_amp", out_amplitude, 20);
        check_eq("s1_e1", out_electrode1, 4'b0001);
        check_eq("s1_e2", out_electrode2, 4'b0100);
        check_eq("s1_ph", out_phase, 3);
        check_eq("s1_busy", busy, 1);
        tick();
        check_eq("s1_one_shot", pulse_start, 0);
        for (int i = 0; i < 7; i++) tick();
        finish_pulse();
        check_eq("s1_gap1_busy", busy, 1);
        tick();
        check_eq("s1_gap2_busy", busy, 1);
        tick();
        check_eq("s1_idle_after", busy, 0);
        check_eq("s1_hold_amp", out_amplitude, 20);

        // Round robin from reset: 0,1,3 then 0,3
        do_reset();
        request(4'b1011);
        serve("rr0", 0, 5, 0);
        serve("rr1", 1, 12, 1);
        serve("rr3", 3, 50, 1);
        request(4'b1001);
        serve("rr0b", 0, 5, 0);
        serve("rr3b", 3, 50, 1);

        // Overrun: ch1 requests twice while ch0 is in WAIT
        request(4'b0001);
        take_start("ov0", 0, 5, 0);
        tick();
        request(4'b0010);
        tick();
        request(4'b0010);
        check_eq("ov_flag", overrun, 4'b0010);
        finish_pulse();
        serve("ov1", 1, 12, 1);
        wait_start(10, f);
        check_eq("ov_once", f, 0);
        check_eq("ov_sticky", overrun, 4'b0010);

        // Watchdog: ch2 never completes, ch3 waits behind it
        request(4'b1100);
        take_start("wd2", 2, 20, 0);
        s = start_cyc;
        for (int k = 0; k < 100 && !timeout_err; k++) tick();
        check_eq("wd_when", cyc - s, TO + 1);
        check_eq("wd_gap_busy", busy, 1);
        take_start("wd3", 3, 50, 0);
        check_eq("wd_next", cyc - s, TO + 1 + GAP + 1);
        tick();
        tick();
        finish_pulse();

        // enable dropped mid-WAIT with ch2 pending
        request(4'b0010);
        take_start("en1", 1, 12, 0);
        tick();
        request(4'b0100);
        tick();
        enable = 1'b0;
        tick();
        check_eq("en_busy", busy, 0);
        check_eq("en_amp", out_amplitude, 0);
        check_eq("en_e1", out_electrode1, 0);
        check_eq("en_ch", active_ch, 0);
        check_eq("en_start", pulse_start, 0);
        check_eq("en_ovr_kept", overrun, 4'b0010);
        check_eq("en_tmo_kept", timeout_err, 1);
        enable = 1'b1;
        wait_start(10, f);
        check_eq("en_no_start", f, 0);

        // rr_ptr survived the disable (last grant ch1): ch2 before ch0.
        // Config change during WAIT must not reach out_*.
        request(4'b0101);
        take_start("cf2", 2, 20, 0);
        tick();
        set_cfg(2, 4'b1111, 4'b1111, 6'd33, 3'd5);
        tick();
        check_eq("cf_amp", out_amplitude, 20);
        check_eq("cf_e1", out_electrode1, 4'b0001);
        check_eq("cf_ph", out_phase, 3);
        finish_pulse();
        serve("cf0", 0, 5, 1);

        // Disabled channel request ignored; clear_flags
        ch_enable = 4'b0111;
        request(4'b1000);
        wait_start(10, f);
        check_eq("dis_no_start", f, 0);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check_eq("clr_ovr", overrun, 0);
        check_eq("clr_tmo", timeout_err, 0);
        check_eq("end_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
